// File: rtl/ps2_key_event_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ps2_key_event_decoder: PS/2 set-2 byte stream -> key events, held-key     |
// | table, shift/ctrl/caps state and press counter.       Revision: 1.0       |
// +---------------------------------------------------------------------------+
module ps2_key_event_decoder #(
  parameter int MAX_KEYS  = 4,
  parameter int CNT_W     = 8,
  parameter bit BCD_COUNT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  output logic             kb_nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic             ev_drop,
  output logic [3:0]       held_count,
  output logic [7:0]       last_code,
  output logic             shift,
  output logic             ctrl,
  output logic             caps_lock,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic                nd_q, nd_d, nd_prev_q, nd_prev_d;
  logic [MAX_KEYS-1:0] tv_q, tv_d, te_q, te_d;
  logic [7:0]          tc_q [MAX_KEYS];
  logic [7:0]          tc_d [MAX_KEYS];
  logic                ev_valid_q, ev_valid_d, ev_ext_q, ev_ext_d;
  logic                ev_break_q, ev_break_d, ev_repeat_q, ev_repeat_d;
  logic                ev_drop_q, ev_drop_d;
  logic [7:0]          ev_code_q, ev_code_d, last_code_q, last_code_d;
  logic [3:0]          held_q, held_d;
  logic                shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                ctrl_q, ctrl_d, caps_q, caps_d;
  logic [CNT_W-1:0]    press_q, press_d;

  logic                accept, fire, brk, ext, hit, have_free, new_press;
  logic [MAX_KEYS-1:0] hit_mask, free_mask;

  function automatic logic is_ignore(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // BCD mode ripples a carry nibble by nibble; all-9s naturally wraps to 0.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             c;
    if (!BCD_COUNT) return v + CNT_W'(1);
    r = v;
    c = 1'b1;
    for (int i = 0; i < CNT_W / 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    tv_d        = tv_q;
    te_d        = te_q;
    tc_d        = tc_q;
    ev_valid_d  = 1'b0;
    ev_drop_d   = 1'b0;
    ev_code_d   = ev_code_q;
    ev_ext_d    = ev_ext_q;
    ev_break_d  = ev_break_q;
    ev_repeat_d = ev_repeat_q;
    last_code_d = last_code_q;
    held_d      = held_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    press_d     = press_q;
    fire        = 1'b0;
    brk         = 1'b0;
    ext         = 1'b0;
    new_press   = 1'b0;

    // A pop strobe needs the strobe high now and on the cycle before.
    accept    = kb_ready & nd_q & nd_prev_q;
    nd_d      = ~accept;
    nd_prev_d = nd_q;

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (kb_data == 8'hE0) state_d = S_EXT;
          else if (kb_data == 8'hF0) state_d = S_BRK;
          else if (kb_data == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_ignore(kb_data)) fire = 1'b1;
        end
        S_EXT: begin
          if (kb_data == 8'hF0) state_d = S_EXT_BRK;
          else if (kb_data == 8'hE0) state_d = S_EXT;
          else begin
            state_d = S_IDLE;
            fire    = !is_ignore(kb_data);
            ext     = 1'b1;
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_d = S_IDLE;
          fire    = !is_ignore(kb_data);
          brk     = 1'b1;
          ext     = (state_q == S_EXT_BRK);
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    hit       = 1'b0;
    have_free = 1'b0;
    hit_mask  = '0;
    free_mask = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (tv_q[i] && te_q[i] == ext && tc_q[i] == kb_data && !hit) begin
        hit         = 1'b1;
        hit_mask[i] = 1'b1;
      end
      if (!tv_q[i] && !have_free) begin
        have_free    = 1'b1;
        free_mask[i] = 1'b1;
      end
    end

    if (fire) begin
      ev_valid_d  = 1'b1;
      ev_code_d   = kb_data;
      ev_ext_d    = ext;
      ev_break_d  = brk;
      ev_repeat_d = 1'b0;
      if (!brk) begin
        if (hit) ev_repeat_d = 1'b1;
        else begin
          new_press   = 1'b1;
          press_d     = cnt_inc(press_q);
          last_code_d = kb_data;
          if (have_free) begin
            for (int i = 0; i < MAX_KEYS; i++) begin
              if (free_mask[i]) begin
                tv_d[i] = 1'b1;
                te_d[i] = ext;
                tc_d[i] = kb_data;
              end
            end
            held_d = held_q + 4'd1;
          end else ev_drop_d = 1'b1;
        end
      end else begin
        if (hit) begin
          tv_d   = tv_q & ~hit_mask;
          held_d = held_q - 4'd1;
        end
        if (kb_data == last_code_q) last_code_d = 8'h00;
      end
      // E0 12 is the fake shift, so shifts only follow non-extended codes.
      if (!ext && kb_data == 8'h12) shift_l_d = !brk;
      if (!ext && kb_data == 8'h59) shift_r_d = !brk;
      if (kb_data == 8'h14) ctrl_d = !brk;
      if (new_press && !ext && kb_data == 8'h58) caps_d = !caps_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      skip_q      <= 3'd0;
      nd_q        <= 1'b1;
      nd_prev_q   <= 1'b1;
      tv_q        <= '0;
      te_q        <= '0;
      for (int i = 0; i < MAX_KEYS; i++) tc_q[i] <= 8'h00;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      ev_repeat_q <= 1'b0;
      ev_drop_q   <= 1'b0;
      last_code_q <= 8'h00;
      held_q      <= 4'd0;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      press_q     <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      nd_q        <= nd_d;
      nd_prev_q   <= nd_prev_d;
      tv_q        <= tv_d;
      te_q        <= te_d;
      tc_q        <= tc_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
      ev_ext_q    <= ev_ext_d;
      ev_break_q  <= ev_break_d;
      ev_repeat_q <= ev_repeat_d;
      ev_drop_q   <= ev_drop_d;
      last_code_q <= last_code_d;
      held_q      <= held_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      press_q     <= press_d;
    end
  end

  assign kb_nextdata_n = nd_q;
  assign ev_valid      = ev_valid_q;
  assign ev_code       = ev_code_q;
  assign ev_ext        = ev_ext_q;
  assign ev_break      = ev_break_q;
  assign ev_repeat     = ev_repeat_q;
  assign ev_drop       = ev_drop_q;
  assign held_count    = held_q;
  assign last_code     = last_code_q;
  assign shift         = shift_l_q | shift_r_q;
  assign ctrl          = ctrl_q;
  assign caps_lock     = caps_q;
  assign press_count   = press_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_decoder.sv
`default_nettype none
// Directed bench for ps2_key_event_decoder: a FIFO model feeds bytes through
// the pop handshake and every decoded event is logged for checking.
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       clrn;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_nextdata_n, ev_valid, ev_ext, ev_break, ev_repeat, ev_drop;
  logic [7:0] ev_code, last_code, press_count;
  logic [3:0] held_count;
  logic       shift, ctrl, caps_lock;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       drop;
  } ev_t;

  logic [7:0] fifo [$];
  ev_t        log_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         pulses = 0;
  int         bad_pulses = 0;
  int         since_low = 100;
  int         bad_pops = 0;

  ps2_key_event_decoder #(.MAX_KEYS(4), .CNT_W(8), .BCD_COUNT(1'b1)) dut (
    .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data),
    .kb_nextdata_n(kb_nextdata_n), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .ev_repeat(ev_repeat),
    .ev_drop(ev_drop), .held_count(held_count), .last_code(last_code),
    .shift(shift), .ctrl(ctrl), .caps_lock(caps_lock),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t ev_at(input int i);
    ev_t e;
    e = '0;
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  // FIFO model: the byte taken at a posedge is removed at the next negedge.
  initial begin
    kb_ready = 1'b0;
    kb_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!kb_nextdata_n) begin
        if (fifo.size() == 0) bad_pops++;
        else void'(fifo.pop_front());
      end
      kb_ready = (fifo.size() != 0);
      kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ev_valid) log_q.push_back('{ev_code, ev_ext, ev_break, ev_repeat, ev_drop});
      if (!kb_nextdata_n) begin
        if (since_low < 2) bad_pulses++;
        pulses++;
        since_low = 0;
      end else since_low++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    log_q.delete();
  endtask

  // Bytes are packed most-significant first: send(3, 64'h1CF01C).
  task automatic send(input int n, input logic [63:0] bytes);
    int k;
    for (int i = n - 1; i >= 0; i--) fifo.push_back(bytes[8*i +: 8]);
    k = 0;
    while (fifo.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain", fifo.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    check("rst_nd", kb_nextdata_n, 1);
    check("rst_valid", ev_valid, 0);
    check("rst_held", held_count, 0);
    check("rst_last", last_code, 0);
    check("rst_press", press_count, 0);
    check("rst_mods", {shift, ctrl, caps_lock, ev_drop}, 0);

    // 1: make then break
    send(1, 64'h1C);
    check("t1_ev", ev_at(0), {8'h1C, 4'b0000});
    check("t1_held", held_count, 1);
    check("t1_last", last_code, 8'h1C);
    check("t1_press", press_count, 8'h01);
    send(2, 64'hF01C);
    check("t1_brk_ev", ev_at(1), {8'h1C, 4'b0100});
    check("t1_brk_held", held_count, 0);
    check("t1_brk_last", last_code, 8'h00);
    check("t1_nev", log_q.size(), 2);

    // 2: typematic repeats
    do_reset();
    send(5, 64'h1C1C1CF01C);
    check("t2_nev", log_q.size(), 4);
    check("t2_rep", {ev_at(0).rep, ev_at(1).rep, ev_at(2).rep, ev_at(3).rep}, 4'b0110);
    check("t2_brk", ev_at(3).brk, 1);
    check("t2_press", press_count, 8'h01);
    check("t2_held", held_count, 0);

    // 3: ext and non-ext 75 are distinct keys
    do_reset();
    send(1, 64'h75);
    check("t3_held1", held_count, 1);
    send(2, 64'hE075);
    check("t3_held2", held_count, 2);
    check("t3_ev2", ev_at(1), {8'h75, 4'b1000});
    send(3, 64'hE0F075);
    check("t3_held3", held_count, 1);
    check("t3_ev3", ev_at(2), {8'h75, 4'b1100});

    // 4: table overflow
    do_reset();
    send(5, 64'h151D242D2C);
    check("t4_drop", ev_at(4), {8'h2C, 4'b0001});
    check("t4_nodrop0", ev_at(0).drop, 0);
    check("t4_held", held_count, 4);
    check("t4_press", press_count, 8'h05);
    check("t4_last", last_code, 8'h2C);
    send(2, 64'hF02C);
    check("t4_held_after", held_count, 4);
    check("t4_last_after", last_code, 8'h00);

    // 5: modifiers and pause
    do_reset();
    send(3, 64'h58F058);
    check("t5_caps1", caps_lock, 1);
    send(3, 64'h58F058);
    check("t5_caps0", caps_lock, 0);
    send(4, 64'h1259F012);
    check("t5_shift1", shift, 1);
    send(2, 64'hF059);
    check("t5_shift0", shift, 0);
    send(2, 64'hE012);
    check("t5_fake_shift", shift, 0);
    send(2, 64'hE014);
    check("t5_ctrl1", ctrl, 1);
    send(3, 64'hE0F014);
    check("t5_ctrl0", ctrl, 0);
    log_q.delete();
    send(8, 64'hE11477E1F014F077);
    check("t5_pause_nev", log_q.size(), 0);
    check("t5_pause_ctrl", ctrl, 0);
    send(1, 64'h1C);
    check("t5_after_pause", ev_at(0), {8'h1C, 4'b0000});

    // 6: reset discards a partial sequence, BCD counting
    do_reset();
    send(1, 64'hE0);
    do_reset();
    send(1, 64'h75);
    check("t6_nev", log_q.size(), 1);
    check("t6_nonext", ev_at(0), {8'h75, 4'b0000});
    do_reset();
    for (int i = 0; i < 10; i++) send(3, 64'h1CF01C);
    check("t6_bcd10", press_count, 8'h10);
    for (int i = 10; i < 99; i++) send(3, 64'h1CF01C);
    check("t6_bcd99", press_count, 8'h99);
    send(3, 64'h1CF01C);
    check("t6_bcd_wrap", press_count, 8'h00);
    check("t6_nd_spacing", bad_pulses, 0);
    check("t6_nd_pulses", pulses > 300, 1);
    check("t6_bad_pops", bad_pops, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
Parametrised successor to the keyboard front-end FSM. It pops bytes from ps2_keyboard through the ready/nextdata_n handshake and decodes PS/2 set-2 make, break, E0-extended and E1-pause sequences into one-cycle key events. It tracks up to MAX_KEYS simultaneously held keys to separate typematic repeats from new presses, and maintains shift, ctrl and caps-lock state plus a press counter. It sits between ps2_keyboard and the scan_code2ascii / data2seg display path.

Parameters:
MAX_KEYS, 4, number of held-key table entries (1..8).
CNT_W, 8, width of press_count.
BCD_COUNT, 1, 1 = press_count counts in BCD (CNT_W multiple of 4); 0 = binary.

Ports:
clk  in  1  system clock
clrn  in  1  synchronous active-low reset
kb_ready  in  1  ps2_keyboard FIFO non-empty
kb_data  in  8  ps2_keyboard FIFO head byte
kb_nextdata_n  out  1  active-low pop strobe to ps2_keyboard
ev_valid  out  1  one-cycle pulse per decoded key event
ev_code  out  8  scan code of the event
ev_ext  out  1  event was E0-prefixed
ev_break  out  1  event is a release
ev_repeat  out  1  make event for a key already held (typematic)
ev_drop  out  1  one-cycle pulse: new press not stored, table full
held_count  out  4  number of valid held-table entries
last_code  out  8  code of the most recent new press; 0 once it is released
shift  out  1  left (12) or right (59) shift held, non-extended only
ctrl  out  1  ctrl (14) held, extended or not
caps_lock  out  1  toggle state
press_count  out  CNT_W  count of new presses

Behaviour:
- Reset (clrn=0 at a clk edge; dominates all other inputs):
  - outputs: all 0, except kb_nextdata_n=1.
  - internal state: FSM to IDLE, held table cleared, E1 skip counter cleared.
  - A partially received sequence is discarded.
- Handshake:
  - A byte is accepted on a cycle where kb_ready=1 and kb_nextdata_n was 1 on both the current and previous cycle.
  - On acceptance, kb_data is registered and kb_nextdata_n=0 for exactly the next cycle.
  - At most one byte is accepted per 3 cycles.
  - A byte is never consumed twice; no byte is popped while kb_ready=0.
- Ignore set: 00, AA, EE, FA, FC, FD, FE, FF.
- FSM, one transition per accepted byte:
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> SKIP, counter=7
    - ignore set -> IDLE, no event
    - any other byte -> make event (ext=0), stay IDLE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> stay EXT
    - ignore set -> IDLE
    - any other byte -> make event (ext=1), go to IDLE
  - BRK: any byte outside the ignore set -> break event (ext=0), go to IDLE; ignore set -> IDLE, no event.
  - EXT_BRK: as BRK, but ext=1.
  - SKIP: decrement per byte, no events; return to IDLE after the 7th byte.
- Event timing:
  - ev_* fields are registered and valid in the cycle after the final byte is accepted; ev_valid is high for exactly 1 cycle.
  - All state updates (table, counters, modifiers) take effect in that same cycle.
  - Fields hold their values between events.
- Held table: entries {valid, ext, code}; a match requires equal ext and equal code.
  - Make with match: ev_repeat=1; table, press_count and last_code unchanged.
  - Make, no match, free slot: insert at the lowest free index; held_count+1; press_count+1; last_code=code.
  - Make, no match, table full: ev_drop=1; ev_repeat=0; press_count+1; last_code=code; not stored.
  - Break with match: clear the entry, held_count-1; if code==last_code, last_code=0.
  - Break with no match: event emitted; table unchanged; last_code cleared only if the code equals it.
- Modifiers:
  - shift_l/shift_r/ctrl flags are set on make and cleared on break of their code, independent of table capacity.
  - shift = shift_l | shift_r. E0 12 (fake shift) does not affect shift.
  - caps_lock toggles on a new (non-repeat) make of non-ext 58.
- press_count wraps modulo 2^CNT_W (binary). In BCD mode, each nibble carries 9->0 and all-9s wraps to 0.

Test Plan:
1. Reset; bytes 1C, F0, 1C -> event make 1C, held_count=1, last_code=1C, press_count=01; then break 1C, held_count=0, last_code=00.
2. Bytes 1C, 1C, 1C, F0, 1C -> one new make, two events with ev_repeat=1, press_count=01, held_count=0 at end.
3. Bytes 75, E0 75, E0 F0 75 -> held_count goes 1, 2, 1; ext break leaves non-ext 75 held; ev_ext=1 on the 2nd and 3rd events.
4. MAX_KEYS=4; make 15, 1D, 24, 2D, 2C -> ev_drop on 2C, held_count=4, press_count=05; F0 2C -> held_count stays 4, last_code=00.
5. Bytes 58 F0 58 58 F0 58 -> caps_lock 1 then 0. Bytes 12, 59, F0 12 -> shift still 1; F0 59 -> shift 0. E1 14 77 E1 F0 14 F0 77 -> no events.
6. kb_ready held high with a queued stream -> kb_nextdata_n low pulses exactly 1 cycle wide, at least 3 cycles apart. Bytes E0, reset, 75 -> non-ext make. BCD: 99 presses -> 8'h99; 100th -> 8'h00.
